// File: rtl/cnn_ofm_reader.sv
// cnn_ofm_reader: drains the CNN output buffer in (m,row,col) order onto a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle read latency so the stream sustains one beat per cycle.
module cnn_ofm_reader #(
    parameter int M_p = 4,
    parameter int R_p = 16,
    parameter int C_p = 16,
    parameter int width_p = 32,
    localparam int MW = (M_p > 1) ? $clog2(M_p) : 1,
    localparam int RW = (R_p > 1) ? $clog2(R_p) : 1,
    localparam int CW = (C_p > 1) ? $clog2(C_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    output logic               rd_en_o,
    output logic [MW-1:0]      rd_m_o,
    output logic [RW-1:0]      rd_row_o,
    output logic [CW-1:0]      rd_col_o,
    input  logic [width_p-1:0] rd_data_i,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic               busy_o,
    output logic               done_o
);
    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t state, state_n;
    logic [MW-1:0] m;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic inflight, inflight_last;
    logic [width_p:0] mem [2];
    logic wr_ptr, rd_ptr;
    logic [1:0] count;
    logic pop, last_addr, col_wrap, row_wrap;

    assign col_wrap  = col == CW'(C_p - 1);
    assign row_wrap  = row == RW'(R_p - 1);
    assign last_addr = col_wrap && row_wrap && m == MW'(M_p - 1);
    assign valid_o   = count != 2'd0;
    assign pop       = valid_o & ready_i;
    assign data_o    = mem[rd_ptr][width_p-1:0];
    assign last_o    = valid_o & mem[rd_ptr][width_p];
    assign busy_o    = state != IDLE;
    assign done_o    = state == DONE;
    assign rd_m_o    = m;
    assign rd_row_o  = row;
    assign rd_col_o  = col;
    // Issue only if the slot freed by this cycle's pop keeps FIFO + in-flight within 2.
    assign rd_en_o   = state == READ && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) state <= IDLE;
        else            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start_i ? READ : IDLE;
            READ:  state_n = (rd_en_o && last_addr) ? FLUSH : READ;
            FLUSH: state_n = (pop && last_o && !inflight && count == 2'd1) ? DONE : FLUSH;
            DONE:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            m   <= '0;
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start_i) begin
            m   <= '0;
            row <= '0;
            col <= '0;
        end else if (rd_en_o) begin
            col <= col_wrap ? '0 : col + 1'b1;
            if (col_wrap) row <= row_wrap ? '0 : row + 1'b1;
            if (col_wrap && row_wrap) m <= (m == MW'(M_p - 1)) ? '0 : m + 1'b1;
        end

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            inflight      <= rd_en_o;
            inflight_last <= rd_en_o & last_addr;
            if (inflight) begin
                mem[wr_ptr] <= {inflight_last, rd_data_i};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end

    always_ff @(posedge clk_i)
        if (reset_n_i && inflight && !pop) assert (count < 2'd2);
endmodule

// File: tb/tb_cnn_ofm_reader.sv
// tb_cnn_ofm_reader: randomized scoreboard bench; expected beats are queued on accepted start
// and popped by an independent monitor that also tracks busy/done timing and occupancy.
module tb_cnn_ofm_reader;
    localparam int M = 2, R = 2, C = 2, E = M * R * C, W = 32;

    logic clk = 0, rst_n = 0, start = 0, ready = 0;
    logic rd_en, valid, last, busy, done;
    logic [0:0] rd_m, rd_row, rd_col;
    logic [W-1:0] rd_data = '0, data, key = '0;

    logic o_start = 0, o_rd_en, o_valid, o_last, o_busy, o_done;
    logic [0:0] o_m, o_r, o_c;
    logic [W-1:0] o_rd_data = '0, o_data;

    int checks = 0, failures = 0, cyc = 0, mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_ofm_reader #(.M_p(M), .R_p(R), .C_p(C), .width_p(W)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .rd_en_o(rd_en),
        .rd_m_o(rd_m), .rd_row_o(rd_row), .rd_col_o(rd_col), .rd_data_i(rd_data),
        .data_o(data), .valid_o(valid), .ready_i(ready), .last_o(last),
        .busy_o(busy), .done_o(done)
    );

    cnn_ofm_reader #(.M_p(1), .R_p(1), .C_p(1), .width_p(W)) u_one (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(o_start), .rd_en_o(o_rd_en),
        .rd_m_o(o_m), .rd_row_o(o_r), .rd_col_o(o_c), .rd_data_i(o_rd_data),
        .data_o(o_data), .valid_o(o_valid), .ready_i(1'b1), .last_o(o_last),
        .busy_o(o_busy), .done_o(o_done)
    );

    // Output buffer contents: m*100 + r*10 + c, scrambled by a per-pass key.
    always @(posedge clk) if (rd_en) rd_data <= key ^ W'(int'(rd_m) * 100 + int'(rd_row) * 10 + int'(rd_col));
    always @(posedge clk) if (o_rd_en) o_rd_data <= 32'h5A5A_0000 | W'(int'(o_m) + int'(o_r) + int'(o_c));

    initial forever begin
        @(posedge clk);
        #2;
        ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~ready : (mode == 2) ? 1'($urandom % 2) : 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {logic [W-1:0] d; logic l;} beat_t;
    beat_t q[$];
    beat_t b;
    bit m_busy = 0, stall_prev = 0, stall_l = 0;
    logic [W-1:0] stall_d = '0;
    int free_cyc = 0, done_exp = -1, outstanding = 0, ai = 0, reads = 0;
    int pass_pops = 0, first_pop = 0, last_pop = 0, done_cyc = 0, done_cnt = 0;

    task automatic clear_model();
        q.delete();
        m_busy = 0; stall_prev = 0; free_cyc = 0; done_exp = -1; outstanding = 0; ai = 0; pass_pops = 0;
    endtask

    always @(negedge clk) if (rst_n) begin
        if (m_busy && cyc >= free_cyc) m_busy = 0;
        chk("busy", busy, m_busy);
        chk("done", done, cyc == done_exp);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (stall_prev) begin
            chk("stall_valid", valid, 1);
            chk("stall_data", data, stall_d);
            chk("stall_last", last, stall_l);
        end
        stall_prev = valid && !ready; stall_d = data; stall_l = last;
        chk("occupancy", outstanding + int'(rd_en) - int'(valid && ready) <= 2, 1);
        outstanding += int'(rd_en) - int'(valid && ready);
        if (rd_en) begin
            chk("addr", int'(rd_m) * 10000 + int'(rd_row) * 100 + int'(rd_col),
                (ai / (R * C)) * 10000 + ((ai / C) % R) * 100 + ai % C);
            ai = (ai + 1) % E;
            reads++;
        end
        if (valid && ready) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL beat: got unexpected beat %0h expected none (cycle %0d)", data, cyc);
            end else begin
                b = q.pop_front();
                chk("data", data, b.d);
                chk("last", last, b.l);
                pass_pops++;
                if (pass_pops == 1) first_pop = cyc;
                if (b.l) begin last_pop = cyc; done_exp = cyc + 1; free_cyc = cyc + 2; end
            end
        end
        if (start && !m_busy) begin
            m_busy = 1; free_cyc = 1 << 30; ai = 0; pass_pops = 0;
            for (int i = 0; i < E; i++) begin
                b.d = key ^ W'((i / (R * C)) * 100 + ((i / C) % R) * 10 + i % C);
                b.l = (i == E - 1);
                q.push_back(b);
            end
        end
    end

    // Call right after a posedge; start is high for exactly one cycle.
    task automatic start_pulse(output int t);
        #1 start = 1;
        t = cyc;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(input int lim);
        int base = done_cnt;
        for (int i = 0; i < lim && done_cnt == base; i++) @(posedge clk);
        chk("done_reached", done_cnt > base, 1);
    endtask

    initial begin
        int t0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, r0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data, 0);
        chk("rst_last", last, 0);
        rst_n = 1;

        // Full-throughput pass with exact cycle timing.
        mode = 0;
        repeat (2) @(posedge clk);
        start_pulse(t0);
        wait_done(200);
        chk("first_beat_cyc", first_pop - t0, 3);
        chk("last_beat_cyc", last_pop - t0, E + 2);
        chk("done_cyc", done_cyc - t0, E + 3);
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Alternating back-pressure.
        mode = 1;
        key = $urandom;
        @(posedge clk);
        start_pulse(t0);
        wait_done(200);

        // Long stall: only two reads may issue.
        mode = 3;
        key = $urandom;
        repeat (2) @(posedge clk);
        r0 = reads;
        start_pulse(t0);
        repeat (19) @(posedge clk);
        #1;
        chk("stall_reads", reads - r0, 2);
        chk("stall_hold_valid", valid, 1);
        chk("stall_hold_data", data, key);
        @(posedge clk);
        #1 mode = 0;
        wait_done(200);
        chk("stall_done_cyc", done_cyc <= t0 + 20 + E + 1, 1);

        // Restart attempts while busy are ignored; then an earliest restart after DONE.
        mode = 2;
        key = $urandom;
        @(posedge clk);
        start_pulse(t0);
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (2) @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_done(400);
        start_pulse(t0);
        wait_done(400);

        // Asynchronous reset after 3 accepted beats.
        mode = 0;
        key = $urandom;
        @(posedge clk);
        start_pulse(t0);
        for (int i = 0; i < 100 && pass_pops < 3; i++) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", data, 0);
        chk("arst_last", last, 0);
        clear_model();
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        start_pulse(t0);
        wait_done(200);
        chk("rst_first_beat_cyc", first_pop - t0, 3);

        // Single-element configuration.
        @(posedge clk);
        #1 o_start = 1;
        t0 = cyc;
        @(posedge clk);
        #1 o_start = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("one_valid", o_valid, k == 3);
            chk("one_last", o_last, k == 3);
            chk("one_done", o_done, k == 4);
            if (k == 3) chk("one_data", o_data, 32'h5A5A_0000);
        end

        // Random back-pressure passes with random gaps.
        mode = 2;
        for (int p = 0; p < 3; p++) begin
            key = $urandom;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            start_pulse(t0);
            wait_done(400);
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
